// File: rtl/simple_uart_rx.sv
// -----------------------------------------------------------------------------
// simple_uart_rx
//
// 8N1 serial receiver. Waits for a falling edge on the synchronized line,
// re-checks the start bit at mid-bit, samples eight data bits (LSB first) at
// bit centres, then checks the stop bit at mid-stop. The FSM returns to IDLE
// right after the stop sample, so a start edge that immediately follows the
// stop bit is still seen.
//
// Parameters
//   SYSTEM_FREQ     clock frequency in Hz
//   BAUD_RATE       line bit rate in bit/s
//
// Ports
//   clock           system clock, rising edge
//   srst            synchronous active-high reset
//   rx_bit          asynchronous serial line, idle high
//   rx_value        last correctly received byte
//   rx_value_valid  one-cycle pulse, rx_value was just updated
//   rx_frame_error  one-cycle pulse, stop bit sampled low
//
// Build option
//   SIMPLE_UART_RX_MAJORITY_EN  when defined, each sample point takes a 2-of-3
//                               majority over nominal-1/nominal/nominal+1 and
//                               decides at nominal+1, so every output pulse
//                               lands one cycle later than in the default build.
//
// State table
//   state   | meaning
//   S_IDLE  | line idle, counters held at 0, watching for a falling edge
//   S_START | waiting for mid-start-bit to confirm the start bit
//   S_DATA  | sampling the 8 data bits, one per bit period
//   S_STOP  | waiting for mid-stop-bit, then publish byte or flag error
// -----------------------------------------------------------------------------
module simple_uart_rx #(
   parameter int SYSTEM_FREQ = 50_000_000,
   parameter int BAUD_RATE   = 9600
) (
   input  logic       clock,
   input  logic       srst,
   input  logic       rx_bit,
   output logic [7:0] rx_value,
   output logic       rx_value_valid,
   output logic       rx_frame_error
);

   localparam int BIT_CYCLES  = SYSTEM_FREQ / BAUD_RATE;
   localparam int HALF_CYCLES = BIT_CYCLES / 2;
   localparam int CNT_W       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   // The counter is cleared in the edge-detect cycle and again at every
   // decision, so it reads (cycles since that event) - 1.  A decision made
   // N cycles after the previous one therefore fires at a count of N-1.
   localparam logic [CNT_W-1:0] BIT_TC = CNT_W'(BIT_CYCLES - 1);
`ifdef SIMPLE_UART_RX_MAJORITY_EN
   // The start decision moves to nominal+1. Data and stop decisions keep the
   // same one-bit spacing, so they also land at nominal+1.
   localparam logic [CNT_W-1:0] START_TC = CNT_W'(HALF_CYCLES);
`else
   localparam logic [CNT_W-1:0] START_TC = CNT_W'(HALF_CYCLES - 1);
`endif

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_baud_cnt;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   logic [7:0]       r_rx_value;
   logic             r_valid;
   logic             r_ferr;

   // r_sync is the synchronized line (rx_sync). r_sync_d is its previous
   // value, used for the falling-edge detect.
   logic r_sync_meta;
   logic r_sync;
   logic r_sync_d;

   logic w_fall;
   logic w_sample;

   assign w_fall = r_sync_d & ~r_sync;

`ifdef SIMPLE_UART_RX_MAJORITY_EN
   logic r_sync_d2;

   always_ff @(posedge clock) begin
      if (srst) begin
         r_sync_d2 <= 1'b1;
      end else begin
         r_sync_d2 <= r_sync_d;
      end
   end

   // At the decision cycle (nominal+1): r_sync is nominal+1, r_sync_d is
   // nominal, and r_sync_d2 is nominal-1.
   assign w_sample = (r_sync_d2 & r_sync_d) |
                     (r_sync_d2 & r_sync)   |
                     (r_sync_d  & r_sync);
`else
   assign w_sample = r_sync;
`endif

   always_ff @(posedge clock) begin
      if (srst) begin
         r_sync_meta <= 1'b1;
         r_sync      <= 1'b1;
         r_sync_d    <= 1'b1;
      end else begin
         r_sync_meta <= rx_bit;
         r_sync      <= r_sync_meta;
         r_sync_d    <= r_sync;
      end
   end

   always_ff @(posedge clock) begin
      if (srst) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_cnt  <= 3'd0;
         r_shift    <= 8'h00;
         r_rx_value <= 8'h00;
         r_valid    <= 1'b0;
         r_ferr     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_baud_cnt <= '0;
               r_bit_cnt  <= 3'd0;
               if (w_fall) begin
                  r_state <= S_START;
               end
            end

            S_START: begin
               if (r_baud_cnt == START_TC) begin
                  r_baud_cnt <= '0;
                  // A line that is high again at mid-start was only a glitch.
                  if (w_sample) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_DATA;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (r_baud_cnt == BIT_TC) begin
                  r_baud_cnt <= '0;
                  // LSB arrives first and ends up in bit 0 after eight shifts.
                  r_shift    <= {w_sample, r_shift[7:1]};
                  if (r_bit_cnt == 3'd7) begin
                     r_bit_cnt <= 3'd0;
                     r_state   <= S_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            S_STOP: begin
               if (r_baud_cnt == BIT_TC) begin
                  r_baud_cnt <= '0;
                  r_state    <= S_IDLE;
                  if (w_sample) begin
                     r_rx_value <= r_shift;
                     r_valid    <= 1'b1;
                  end else begin
                     r_ferr     <= 1'b1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            default: begin
               r_state    <= S_IDLE;
               r_baud_cnt <= '0;
               r_bit_cnt  <= 3'd0;
            end
         endcase
      end
   end

   assign rx_value       = r_rx_value;
   assign rx_value_valid = r_valid;
   assign rx_frame_error = r_ferr;

endmodule

// File: tb/tb_simple_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_simple_uart_rx
//
// The bench builds each line waveform as a bit array, one entry per clock. It
// plays the array into rx_bit and records every output pulse with its cycle
// index. A reference model applies the receiver rules directly to the same
// array and predicts the pulses:
//   - a start is a high-to-low step in the line;
//   - the line is sampled at HALF + n*BIT after that step;
//   - results appear 3 cycles after the decision point (2 synchronizer
//     stages plus 1 output register).
// A scaled bit period of 101 clocks (HALF = 50) keeps the run short.
// -----------------------------------------------------------------------------
module tb_simple_uart_rx;

   localparam int SYS_F = 1_015_000;
   localparam int BAUD  = 10_000;
   localparam int BIT   = SYS_F / BAUD;
   localparam int HALF  = BIT / 2;
`ifdef SIMPLE_UART_RX_MAJORITY_EN
   localparam bit MAJ = 1'b1;
`else
   localparam bit MAJ = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       srst  = 1'b1;
   logic       rx_bit = 1'b1;
   logic [7:0] rx_value;
   logic       rx_value_valid;
   logic       rx_frame_error;

   int n_cmp  = 0;
   int n_fail = 0;

   // Each event packs {cycle[31:0], kind[1:0] = {error, valid}, rx_value[7:0]}.
   bit          g_line[$];
   logic [41:0] g_exp[$];
   logic [41:0] g_obs[$];
   logic [7:0]  exp_val = 8'h00;

   simple_uart_rx #(.SYSTEM_FREQ(SYS_F), .BAUD_RATE(BAUD)) dut (
      .clock          (clock),
      .srst           (srst),
      .rx_bit         (rx_bit),
      .rx_value       (rx_value),
      .rx_value_valid (rx_value_valid),
      .rx_frame_error (rx_frame_error)
   );

   always #5 clock = ~clock;

   function automatic bit getl(int i);
      if (i >= 0 && i < g_line.size()) return g_line[i];
      return 1'b1;
   endfunction

   function automatic bit samp(int n);
      if (MAJ) return (getl(n-1) & getl(n)) | (getl(n-1) & getl(n+1)) | (getl(n) & getl(n+1));
      return getl(n);
   endfunction

   task automatic add_idle(int n);
      repeat (n) g_line.push_back(1'b1);
   endtask

   task automatic add_frame(logic [7:0] b, bit stop);
      repeat (BIT) g_line.push_back(1'b0);
      for (int k = 0; k < 8; k++) repeat (BIT) g_line.push_back(b[k]);
      repeat (BIT) g_line.push_back(stop);
   endtask

   task automatic model();
      int idx, e, d, lag;
      bit prev;
      logic [7:0] sh;
      lag  = MAJ ? 1 : 0;
      g_exp.delete();
      idx  = 0;
      prev = 1'b1;
      sh   = 8'h00;
      while (idx < g_line.size()) begin
         if (prev && !getl(idx)) begin
            e = idx;
            if (samp(e + HALF)) begin
               d = e + HALF + lag;
            end else begin
               for (int k = 0; k < 8; k++) sh[k] = samp(e + HALF + (k+1)*BIT);
               d = e + HALF + 9*BIT + lag;
               if (samp(e + HALF + 9*BIT)) begin
                  exp_val = sh;
                  g_exp.push_back({32'(d+3), 2'b01, sh});
               end else begin
                  g_exp.push_back({32'(d+3), 2'b10, exp_val});
               end
            end
            prev = getl(d);
            idx  = d + 1;
         end else begin
            prev = getl(idx);
            idx++;
         end
      end
   endtask

   task automatic play();
      int n;
      n = g_line.size() + 8;
      g_obs.delete();
      for (int j = 0; j < n; j++) begin
         @(negedge clock);
         if (rx_value_valid || rx_frame_error)
            g_obs.push_back({32'(j), rx_frame_error, rx_value_valid, rx_value});
         rx_bit = (j < g_line.size()) ? g_line[j] : 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      n_cmp++; if (rx_value !== 8'h00) begin n_fail++; $display("FAIL reset rx_value: got %h want 00", rx_value); end
      n_cmp++; if (rx_value_valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b want 0", rx_value_valid); end
      n_cmp++; if (rx_frame_error !== 1'b0) begin n_fail++; $display("FAIL reset frame_error: got %b want 0", rx_frame_error); end
      srst = 1'b0;
      exp_val = 8'h00;
      repeat (5) @(negedge clock);
   endtask

   task automatic test_good_frame();
      g_line.delete(); add_idle(10); add_frame(8'hA5, 1'b1); add_idle(BIT);
      model(); play();
      n_cmp++; if (g_obs.size() != g_exp.size()) begin n_fail++; $display("FAIL good_frame pulses: got %0d want %0d", g_obs.size(), g_exp.size()); end
      foreach (g_exp[i]) if (i < g_obs.size()) begin
         n_cmp++; if (g_obs[i] !== g_exp[i]) begin n_fail++; $display("FAIL good_frame pulse %0d: got cyc=%0d kind=%b val=%h want cyc=%0d kind=%b val=%h", i, g_obs[i][41:10], g_obs[i][9:8], g_obs[i][7:0], g_exp[i][41:10], g_exp[i][9:8], g_exp[i][7:0]); end
      end
      n_cmp++; if (rx_value !== 8'hA5) begin n_fail++; $display("FAIL good_frame rx_value: got %h want a5", rx_value); end
   endtask

   task automatic test_frame_error();
      g_line.delete(); add_idle(10); add_frame(8'h3C, 1'b0); add_idle(BIT);
      model(); play();
      n_cmp++; if (g_obs.size() != g_exp.size()) begin n_fail++; $display("FAIL frame_error pulses: got %0d want %0d", g_obs.size(), g_exp.size()); end
      foreach (g_exp[i]) if (i < g_obs.size()) begin
         n_cmp++; if (g_obs[i] !== g_exp[i]) begin n_fail++; $display("FAIL frame_error pulse %0d: got cyc=%0d kind=%b val=%h want cyc=%0d kind=%b val=%h", i, g_obs[i][41:10], g_obs[i][9:8], g_obs[i][7:0], g_exp[i][41:10], g_exp[i][9:8], g_exp[i][7:0]); end
      end
      n_cmp++; if (g_obs.size() != 1 || g_obs[0][9:8] !== 2'b10) begin n_fail++; $display("FAIL frame_error kind: got %0d pulses, first kind %b, want one pulse kind 10", g_obs.size(), (g_obs.size() > 0) ? g_obs[0][9:8] : 2'b00); end
      n_cmp++; if (rx_value !== 8'hA5) begin n_fail++; $display("FAIL frame_error rx_value held: got %h want a5", rx_value); end
   endtask

   task automatic test_short_low_pulse();
      g_line.delete(); add_idle(10);
      repeat (20) g_line.push_back(1'b0);
      add_idle(2*BIT); add_frame(8'h5A, 1'b1); add_idle(BIT);
      model(); play();
      n_cmp++; if (g_obs.size() != g_exp.size()) begin n_fail++; $display("FAIL short_low pulses: got %0d want %0d", g_obs.size(), g_exp.size()); end
      foreach (g_exp[i]) if (i < g_obs.size()) begin
         n_cmp++; if (g_obs[i] !== g_exp[i]) begin n_fail++; $display("FAIL short_low pulse %0d: got cyc=%0d kind=%b val=%h want cyc=%0d kind=%b val=%h", i, g_obs[i][41:10], g_obs[i][9:8], g_obs[i][7:0], g_exp[i][41:10], g_exp[i][9:8], g_exp[i][7:0]); end
      end
      n_cmp++; if (rx_value !== 8'h5A) begin n_fail++; $display("FAIL short_low rx_value: got %h want 5a", rx_value); end
   endtask

   task automatic test_back_to_back();
      g_line.delete(); add_idle(10); add_frame(8'h00, 1'b1); add_frame(8'hFF, 1'b1); add_idle(BIT);
      model(); play();
      n_cmp++; if (g_obs.size() != g_exp.size()) begin n_fail++; $display("FAIL back_to_back pulses: got %0d want %0d", g_obs.size(), g_exp.size()); end
      foreach (g_exp[i]) if (i < g_obs.size()) begin
         n_cmp++; if (g_obs[i] !== g_exp[i]) begin n_fail++; $display("FAIL back_to_back pulse %0d: got cyc=%0d kind=%b val=%h want cyc=%0d kind=%b val=%h", i, g_obs[i][41:10], g_obs[i][9:8], g_obs[i][7:0], g_exp[i][41:10], g_exp[i][9:8], g_exp[i][7:0]); end
      end
      n_cmp++; if (g_obs.size() != 2 || g_obs[0][7:0] !== 8'h00 || g_obs[1][7:0] !== 8'hFF) begin n_fail++; $display("FAIL back_to_back values: got %0d pulses, want 2 pulses with 00 then ff", g_obs.size()); end
   endtask

   task automatic test_srst_mid_frame();
      int abort_at, pulses;
      g_line.delete(); add_frame(8'h81, 1'b1); add_idle(BIT);
      abort_at = HALF + 5*BIT;
      pulses   = 0;
      for (int j = 0; j < g_line.size(); j++) begin
         @(negedge clock);
         if (rx_value_valid || rx_frame_error) pulses++;
         if (j == abort_at) srst = 1'b1;
         if (j == abort_at + 3) begin
            n_cmp++; if (rx_value !== 8'h00 || rx_value_valid !== 1'b0 || rx_frame_error !== 1'b0) begin n_fail++; $display("FAIL srst_mid outputs: got %h/%b/%b want 00/0/0", rx_value, rx_value_valid, rx_frame_error); end
         end
         rx_bit = g_line[j];
      end
      @(negedge clock);
      srst = 1'b0;
      exp_val = 8'h00;
      repeat (20) begin
         @(negedge clock);
         if (rx_value_valid || rx_frame_error) pulses++;
      end
      n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL srst_mid pulses: got %0d want 0", pulses); end
      g_line.delete(); add_idle(10); add_frame(8'h7E, 1'b1); add_idle(BIT);
      model(); play();
      n_cmp++; if (g_obs.size() != g_exp.size()) begin n_fail++; $display("FAIL srst_next pulses: got %0d want %0d", g_obs.size(), g_exp.size()); end
      foreach (g_exp[i]) if (i < g_obs.size()) begin
         n_cmp++; if (g_obs[i] !== g_exp[i]) begin n_fail++; $display("FAIL srst_next pulse %0d: got cyc=%0d kind=%b val=%h want cyc=%0d kind=%b val=%h", i, g_obs[i][41:10], g_obs[i][9:8], g_obs[i][7:0], g_exp[i][41:10], g_exp[i][9:8], g_exp[i][7:0]); end
      end
      n_cmp++; if (rx_value !== 8'h7E) begin n_fail++; $display("FAIL srst_next rx_value: got %h want 7e", rx_value); end
   endtask

   task automatic test_sample_glitch();
      int f;
      logic [7:0] prev_val;
      prev_val = exp_val;
      g_line.delete(); add_idle(10);
      f = g_line.size();
      add_frame(8'h55, 1'b1); add_idle(BIT);
      for (int k = 0; k < 8; k++) g_line[f + HALF + (k+1)*BIT] = ~g_line[f + HALF + (k+1)*BIT];
      g_line[f + HALF + 9*BIT] = ~g_line[f + HALF + 9*BIT];
      model(); play();
      n_cmp++; if (g_obs.size() != g_exp.size()) begin n_fail++; $display("FAIL sample_glitch pulses: got %0d want %0d", g_obs.size(), g_exp.size()); end
      foreach (g_exp[i]) if (i < g_obs.size()) begin
         n_cmp++; if (g_obs[i] !== g_exp[i]) begin n_fail++; $display("FAIL sample_glitch pulse %0d: got cyc=%0d kind=%b val=%h want cyc=%0d kind=%b val=%h", i, g_obs[i][41:10], g_obs[i][9:8], g_obs[i][7:0], g_exp[i][41:10], g_exp[i][9:8], g_exp[i][7:0]); end
      end
      if (MAJ) begin
         n_cmp++; if (rx_value !== 8'h55) begin n_fail++; $display("FAIL sample_glitch rx_value: got %h want 55", rx_value); end
      end else begin
         n_cmp++; if (rx_value !== prev_val) begin n_fail++; $display("FAIL sample_glitch rx_value held: got %h want %h", rx_value, prev_val); end
      end
   endtask

   task automatic test_break();
      g_line.delete(); add_idle(5);
      repeat (12*BIT) g_line.push_back(1'b0);
      add_idle(2*BIT);
      model(); play();
      n_cmp++; if (g_obs.size() != 1 || g_obs[0][9:8] !== 2'b10) begin n_fail++; $display("FAIL break pulses: got %0d pulses, want a single frame error", g_obs.size()); end
      foreach (g_exp[i]) if (i < g_obs.size()) begin
         n_cmp++; if (g_obs[i] !== g_exp[i]) begin n_fail++; $display("FAIL break pulse %0d: got cyc=%0d kind=%b val=%h want cyc=%0d kind=%b val=%h", i, g_obs[i][41:10], g_obs[i][9:8], g_obs[i][7:0], g_exp[i][41:10], g_exp[i][9:8], g_exp[i][7:0]); end
      end
   endtask

   task automatic test_random();
      bit prev_err, stop;
      int gap, len;
      g_line.delete(); add_idle(10);
      prev_err = 1'b0;
      for (int f = 0; f < 6; f++) begin
         if ($urandom_range(0, 3) == 0) begin
            add_idle(3);
            len = $urandom_range(1, HALF - 3);
            repeat (len) g_line.push_back(1'b0);
            add_idle(HALF + 5);
         end
         gap  = $urandom_range(prev_err ? 1 : 0, BIT);
         stop = ($urandom_range(0, 4) != 0);
         add_idle(gap);
         add_frame(8'($urandom_range(0, 255)), stop);
         prev_err = !stop;
      end
      add_idle(2*BIT);
      model(); play();
      n_cmp++; if (g_obs.size() != g_exp.size()) begin n_fail++; $display("FAIL random pulses: got %0d want %0d", g_obs.size(), g_exp.size()); end
      foreach (g_exp[i]) if (i < g_obs.size()) begin
         n_cmp++; if (g_obs[i] !== g_exp[i]) begin n_fail++; $display("FAIL random pulse %0d: got cyc=%0d kind=%b val=%h want cyc=%0d kind=%b val=%h", i, g_obs[i][41:10], g_obs[i][9:8], g_obs[i][7:0], g_exp[i][41:10], g_exp[i][9:8], g_exp[i][7:0]); end
      end
      n_cmp++; if (rx_value !== exp_val) begin n_fail++; $display("FAIL random rx_value: got %h want %h", rx_value, exp_val); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_frame_error();
      test_short_low_pulse();
      test_back_to_back();
      test_srst_mid_frame();
      test_sample_glitch();
      test_break();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
